// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard matrix front end.
package ps2_pkg;

  localparam logic [7:0] PS2_E0       = 8'hE0;
  localparam logic [7:0] PS2_F0       = 8'hF0;
  localparam logic [7:0] PS2_OVR0     = 8'h00;
  localparam logic [7:0] PS2_OVR1     = 8'hFF;
  localparam logic [7:0] PS2_FAKE_LSH = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSH = 8'h59;

  // Row field is sized for the widest supported matrix; the top only
  // writes rows that exist, so narrower ADDR_W settings stay safe.
  localparam int KP_ROW_W = 8;

  typedef struct packed {
    logic                valid;
    logic [KP_ROW_W-1:0] row;
    logic [2:0]          col;
    logic                valid2;
    logic [KP_ROW_W-1:0] row2;
    logic [2:0]          col2;
  } keypos_t;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Keyboard ack / BAT / echo / resend bytes carry no key information.
  function automatic logic is_ack(input logic [7:0] c);
    return (c == 8'hAA) || (c == 8'hFA) || (c == 8'hEE) || (c == 8'hFE);
  endfunction

  function automatic keypos_t kp1(input int r, input int c);
    keypos_t p;
    p       = '0;
    p.valid = 1'b1;
    p.row   = KP_ROW_W'(r);
    p.col   = 3'(c);
    return p;
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Machine-specific scan-code to matrix-position table ({e0, code} -> keypos_t).
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic       e0,
  input  logic [7:0] code,
  output keypos_t    pos
);

  // Pure lookup; unknown codes return an all-invalid position.
  always_comb begin
    pos = '0;
    case ({e0, code})
      9'h01C: pos = kp1(4, 0);   // A
      9'h01B: pos = kp1(4, 1);   // S
      9'h023: pos = kp1(4, 2);   // D
      9'h012: pos = kp1(8, 0);   // left shift
      9'h059: pos = kp1(8, 1);   // right shift
      9'h05A: pos = kp1(9, 0);   // enter
      9'h029: begin              // space drives two matrix positions
        pos        = kp1(9, 1);
        pos.valid2 = 1'b1;
        pos.row2   = KP_ROW_W'(13);
        pos.col2   = 3'd7;
      end
      9'h175: pos = kp1(9, 2);   // cursor up
      9'h172: pos = kp1(9, 3);   // cursor down
      default: pos = '0;
    endcase
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 receiver (sync, glitch filter, framed FSM with timeout) feeding a
// make/break decoder that maintains an active-low key matrix read by the CPU.
module ps2_keymatrix
  import ps2_pkg::*;
#(
  parameter int ROWS         = 15,
  parameter int ADDR_W       = 4,
  parameter int FILT_LEN     = 4,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int PARITY_CHECK = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              cs,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              key_any,
  output logic              code_valid,
  output logic [7:0]        code,
  output logic              frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]            clk_sync, dat_sync;
  logic                  filt, fall, bit_in;
  logic [2:0]            fcnt;
  rx_state_t             state, nstate;
  logic [7:0]            shreg;
  logic [2:0]            bcnt;
  logic                  par;
  logic [TO_W-1:0]       to_cnt;
  logic                  timeout, frame_ok, frame_bad;
  logic [ROWS-1:0][7:0]  matrix;
  logic [7:0]            rd_row;
  logic                  e0, f0;
  keypos_t               pos;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Glitch filter: accept a clock level only after FILT_LEN differing samples;
  // latch the data bit together with the falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt   <= 1'b1;
      fcnt   <= '0;
      fall   <= 1'b0;
      bit_in <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == 3'(FILT_LEN - 1)) begin
        filt   <= clk_sync[1];
        fcnt   <= '0;
        fall   <= filt;
        bit_in <= dat_sync[1];
      end else begin
        fcnt <= fcnt + 3'd1;
      end
    end
  end

  assign timeout = (state != RX_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Receiver state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= nstate;
  end

  // Receiver next-state; a timeout overrides any in-frame progress.
  always_comb begin
    nstate = state;
    case (state)
      RX_IDLE:   if (fall && !bit_in)          nstate = RX_DATA;
      RX_DATA:   if (fall && bcnt == 3'd7)     nstate = RX_PARITY;
      RX_PARITY: if (fall)                     nstate = RX_STOP;
      RX_STOP:   if (fall)                     nstate = RX_IDLE;
      default:                                 nstate = RX_IDLE;
    endcase
    if (timeout) nstate = RX_IDLE;
  end

  // Receiver outputs: frame verdict on the stop-bit edge or on timeout.
  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (state == RX_STOP && fall) begin
      if (bit_in && ((PARITY_CHECK == 0) || (^{shreg, par}))) frame_ok  = 1'b1;
      else                                                   frame_bad = 1'b1;
    end
    if (timeout) frame_bad = 1'b1;
  end

  // Receiver datapath: LSB-first shift, parity capture, inactivity counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      bcnt   <= '0;
      par    <= 1'b0;
      to_cnt <= '0;
    end else begin
      if (state == RX_IDLE) bcnt <= '0;
      if (fall) begin
        if (state == RX_DATA) begin
          shreg <= {bit_in, shreg[7:1]};
          bcnt  <= bcnt + 3'd1;
        end
        if (state == RX_PARITY) par <= bit_in;
      end
      if (fall || state == RX_IDLE) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;
    end
  end

  // Registered frame result pulses and captured scan byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      code       <= 8'h00;
    end else begin
      code_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) code <= shreg;
    end
  end

  ps2_keymap u_keymap (
    .e0   (e0),
    .code (code),
    .pos  (pos)
  );

  // Make/break decoder acting on the code_valid cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix <= '1;
      e0     <= 1'b0;
      f0     <= 1'b0;
    end else if (code_valid) begin
      if (code == PS2_E0) begin
        e0 <= 1'b1;
      end else if (code == PS2_F0) begin
        f0 <= 1'b1;
      end else if (is_ack(code)) begin
        e0 <= e0;
      end else if (code == PS2_OVR0 || code == PS2_OVR1) begin
        matrix <= '1;
        e0     <= 1'b0;
        f0     <= 1'b0;
      end else begin
        // Extended shift codes are the keyboard's fake shifts: drop them.
        if (!(e0 && (code == PS2_FAKE_LSH || code == PS2_FAKE_RSH))) begin
          for (int r = 0; r < ROWS; r++) begin
            if (pos.valid  && pos.row  == KP_ROW_W'(r)) matrix[r][pos.col]  <= f0;
            if (pos.valid2 && pos.row2 == KP_ROW_W'(r)) matrix[r][pos.col2] <= f0;
          end
        end
        e0 <= 1'b0;
        f0 <= 1'b0;
      end
    end else if (frame_err) begin
      e0 <= 1'b0;
      f0 <= 1'b0;
    end
  end

  // Row mux; rows beyond the matrix read as all released.
  always_comb begin
    rd_row = 8'hFF;
    for (int r = 0; r < ROWS; r++)
      if (addr == ADDR_W'(r)) rd_row = matrix[r];
  end

  // Read port and key_any, both sampling the pre-update matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data    <= 8'hFF;
      key_any <= 1'b0;
    end else begin
      if (cs && rd) data <= rd_row;
      key_any <= (matrix != '1);
    end
  end

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: table-driven key sequences, hand-written error,
// timeout and reset cases, then random frames against a key-state model.
module tb_ps2_keymatrix;

  localparam int ROWS     = 15;
  localparam int ADDR_W   = 4;
  localparam int FILT_LEN = 4;
  localparam int TMO      = 300;
  localparam int HP       = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic              cs = 1'b0;
  logic              rd = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        data;
  logic              key_any;
  logic              code_valid;
  logic [7:0]        code;
  logic              frame_err;

  always #5 clk = ~clk;

  ps2_keymatrix #(
    .ROWS(ROWS), .ADDR_W(ADDR_W), .FILT_LEN(FILT_LEN),
    .TIMEOUT_CYC(TMO), .PARITY_CHECK(1)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .cs(cs), .rd(rd), .addr(addr), .data(data), .key_any(key_any),
    .code_valid(code_valid), .code(code), .frame_err(frame_err)
  );

  int         cyc = 0;
  int         nv = 0;
  int         fe_cnt = 0;
  int         err_cyc = 0;
  logic [7:0] last_code = 8'h00;
  int         fall_cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      nv        <= nv + 1;
      last_code <= code;
    end
    if (frame_err) begin
      fe_cnt  <= fe_cnt + 1;
      err_cyc <= cyc;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model (pressed = 1) ----------------
  bit pressed [ROWS][8];
  bit m_e0, m_f0;

  function automatic int keymap(input bit e, input logic [7:0] c,
                                output int r1, output int c1, output int r2, output int c2);
    r1 = 0; c1 = 0; r2 = 0; c2 = 0;
    if (!e) begin
      case (c)
        8'h1C: begin r1 = 4; c1 = 0; return 1; end
        8'h1B: begin r1 = 4; c1 = 1; return 1; end
        8'h23: begin r1 = 4; c1 = 2; return 1; end
        8'h12: begin r1 = 8; c1 = 0; return 1; end
        8'h59: begin r1 = 8; c1 = 1; return 1; end
        8'h5A: begin r1 = 9; c1 = 0; return 1; end
        8'h29: begin r1 = 9; c1 = 1; r2 = 13; c2 = 7; return 2; end
        default: return 0;
      endcase
    end else begin
      case (c)
        8'h75: begin r1 = 9; c1 = 2; return 1; end
        8'h72: begin r1 = 9; c1 = 3; return 1; end
        default: return 0;
      endcase
    end
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 8; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic model_code(input logic [7:0] c);
    int n, r1, c1, r2, c2;
    if (c == 8'hE0) m_e0 = 1'b1;
    else if (c == 8'hF0) m_f0 = 1'b1;
    else if (c == 8'hAA || c == 8'hFA || c == 8'hEE || c == 8'hFE) begin end
    else if (c == 8'h00 || c == 8'hFF) begin
      model_clear();
      m_e0 = 1'b0; m_f0 = 1'b0;
    end else begin
      if (!(m_e0 && (c == 8'h12 || c == 8'h59))) begin
        n = keymap(m_e0, c, r1, c1, r2, c2);
        if (n >= 1) pressed[r1][c1] = !m_f0;
        if (n == 2) pressed[r2][c2] = !m_f0;
      end
      m_e0 = 1'b0; m_f0 = 1'b0;
    end
  endtask

  function automatic logic [7:0] exp_row(input int a);
    logic [7:0] v;
    v = 8'hFF;
    if (a < ROWS)
      for (int c = 0; c < 8; c++) v[c] = !pressed[a][c];
    return v;
  endfunction

  function automatic logic exp_any();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 8; c++) if (pressed[r][c]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic ps2_send(input logic [7:0] b, input bit bad_par, input bit stop_bit, input int nbits);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (HP/2) @(negedge clk);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HP/2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    int v0, e0c;
    v0 = nv; e0c = fe_cnt;
    ps2_send(b, 1'b0, 1'b1, 11);
    repeat (4) @(negedge clk);
    chk("code_valid_count", nv, v0 + 1);
    chk("code_value", last_code, b);
    chk("no_frame_err", fe_cnt, e0c);
    model_code(b);
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit stop_bit);
    int v0, e0c;
    v0 = nv; e0c = fe_cnt;
    ps2_send(b, bad_par, stop_bit, 11);
    repeat (4) @(negedge clk);
    chk("bad_frame_err", fe_cnt, e0c + 1);
    chk("bad_no_valid", nv, v0);
    m_e0 = 1'b0; m_f0 = 1'b0;
  endtask

  task automatic read_row(input int a, output logic [7:0] v, output logic any);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = ADDR_W'(a);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    v = data; any = key_any;
  endtask

  task automatic read_chk(input int a, input string nm);
    logic [7:0] v;
    logic any;
    read_row(a, v, any);
    chk(nm, v, exp_row(a));
    chk({nm, "_key_any"}, any, exp_any());
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         n;
    logic [7:0] b [3];
    int         a;
    logic [7:0] row;
    logic       any;
  } vec_t;

  vec_t tv [9];

  task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int a, input logic [7:0] row, input logic any);
    tv[i].n = n; tv[i].b[0] = b0; tv[i].b[1] = b1; tv[i].b[2] = b2;
    tv[i].a = a; tv[i].row = row; tv[i].any = any;
  endtask

  logic [7:0] pool [16] = '{8'h1C, 8'h1B, 8'h23, 8'h12, 8'h59, 8'h29, 8'h5A, 8'h75,
                            8'h72, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'h66};

  initial begin
    logic [7:0] v;
    logic       any;
    int         v0, e0c, d, waited;

    set_vec(0, 1, 8'h1C, 8'h00, 8'h00, 4, 8'hFE, 1'b1);
    set_vec(1, 2, 8'hF0, 8'h1C, 8'h00, 4, 8'hFF, 1'b0);
    set_vec(2, 2, 8'hE0, 8'h75, 8'h00, 9, 8'hFB, 1'b1);
    set_vec(3, 3, 8'hE0, 8'hF0, 8'h75, 9, 8'hFF, 1'b0);
    set_vec(4, 1, 8'h12, 8'h00, 8'h00, 8, 8'hFE, 1'b1);
    set_vec(5, 2, 8'hE0, 8'h12, 8'h00, 8, 8'hFE, 1'b1);
    set_vec(6, 2, 8'hF0, 8'h12, 8'h00, 8, 8'hFF, 1'b0);
    set_vec(7, 2, 8'hAA, 8'h1B, 8'h00, 4, 8'hFD, 1'b1);
    set_vec(8, 2, 8'hF0, 8'h1B, 8'h00, 4, 8'hFF, 1'b0);

    model_clear();
    m_e0 = 1'b0; m_f0 = 1'b0;

    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_data", data, 8'hFF);
    chk("rst_key_any", key_any, 1'b0);
    chk("rst_code_valid", code_valid, 1'b0);
    chk("rst_code", code, 8'h00);
    chk("rst_frame_err", frame_err, 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven make/break sequences
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < tv[i].n; j++) send_good(tv[i].b[j]);
      read_row(tv[i].a, v, any);
      chk("vec_row", v, tv[i].row);
      chk("vec_key_any", any, tv[i].any);
    end

    // Read data holds when not selected
    send_good(8'h1C);
    read_row(4, v, any);
    @(negedge clk); addr = 4'd0;
    repeat (3) @(negedge clk);
    chk("data_hold", data, 8'hFE);
    send_good(8'hF0); send_good(8'h1C);

    // Bad parity and bad stop: error pulse, matrix untouched
    send_bad(8'h1C, 1'b1, 1'b1);
    read_chk(4, "bad_par_row4");
    send_bad(8'h1C, 1'b0, 1'b0);
    read_chk(4, "bad_stop_row4");

    // frame_err clears a pending E0: plain 75 is not mapped
    send_good(8'hE0);
    send_bad(8'h55, 1'b1, 1'b1);
    send_good(8'h75);
    read_row(9, v, any);
    chk("e0_cleared_row9", v, 8'hFF);

    // Timeout after 5 bits
    v0 = nv; e0c = fe_cnt;
    ps2_send(8'h1C, 1'b0, 1'b1, 5);
    waited = 0;
    while (fe_cnt == e0c && waited < TMO + 60) begin
      @(negedge clk);
      waited++;
    end
    chk("timeout_err_seen", fe_cnt, e0c + 1);
    d = err_cyc - fall_cyc;
    chk("timeout_latency_window", (d >= TMO && d <= TMO + FILT_LEN + 6), 1'b1);
    chk("timeout_no_valid", nv, v0);
    m_e0 = 1'b0; m_f0 = 1'b0;
    send_good(8'h29);
    read_row(9, v, any);
    chk("space_row9", v, 8'hFD);
    read_row(13, v, any);
    chk("space_row13", v, 8'h7F);

    // Overrun releases everything
    send_good(8'h1C); send_good(8'h1B);
    read_row(4, v, any);
    chk("as_row4", v, 8'hFC);
    chk("as_key_any", any, 1'b1);
    send_good(8'h00);
    for (int r = 0; r < ROWS; r++) read_chk(r, "overrun_row");
    read_row(15, v, any);
    chk("oob_addr15", v, 8'hFF);

    // Reset in the middle of a frame
    send_good(8'h1C);
    read_row(4, v, any);
    e0c = fe_cnt;
    ps2_send(8'h1B, 1'b0, 1'b1, 4);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_data", data, 8'hFF);
    chk("midrst_key_any", key_any, 1'b0);
    chk("midrst_code", code, 8'h00);
    chk("midrst_cv", code_valid, 1'b0);
    reset = 1'b1;
    model_clear();
    m_e0 = 1'b0; m_f0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_err", fe_cnt, e0c);
    send_good(8'h1C);
    read_chk(4, "after_rst_row4");

    // Random frames against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) send_bad(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      else                           send_good(pool[$urandom_range(0, 15)]);
      if (it % 2 == 1) read_chk($urandom_range(0, 15), "rand_row");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
    $finish;
  end

endmodule
